// File: rtl/jtopl_timer_ctrl_if.sv
// jtopl_timer_ctrl_if: CPU bus between the host and the OPL timer register front end
interface jtopl_timer_ctrl_if;
  logic       addr;
  logic [7:0] din;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] dout;
  modport master (output addr, din, cs_n, wr_n, rd_n, input dout);
  modport slave (input addr, din, cs_n, wr_n, rd_n, output dout);
endinterface

// File: rtl/jtopl_timer_ctrl.sv
// jtopl_timer_ctrl: CPU register decode, status readback and CSM key-on for the OPL timer pair
module jtopl_timer_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cenop,
  input  logic                     zero,
  jtopl_timer_ctrl_if.slave        bus,
  output logic [7:0]               value_A,
  output logic [7:0]               value_B,
  output logic                     load_A,
  output logic                     load_B,
  output logic                     clr_flag_A,
  output logic                     clr_flag_B,
  output logic                     flagen_A,
  output logic                     flagen_B,
  input  logic                     flag_A,
  input  logic                     flag_B,
  input  logic                     overflow_A,
  output logic                     csm,
  output logic                     nts,
  output logic                     csm_keyon
);
  logic [7:0] sel;
  logic       wr, wr_last, wev, irq_clr, mask_A, mask_B, ovf_d, rise;
  assign wr         = ~bus.cs_n & ~bus.wr_n;
  assign wev        = wr & ~wr_last;
  assign rise       = overflow_A & ~ovf_d;
  assign flagen_A   = ~mask_A;
  assign flagen_B   = ~mask_B;
  assign clr_flag_A = irq_clr | mask_A;
  assign clr_flag_B = irq_clr | mask_B;
  // one register update per write strobe, no matter how long the strobe is held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel     <= 8'd0;
      wr_last <= 1'b0;
      irq_clr <= 1'b0;
      value_A <= 8'd0;
      value_B <= 8'd0;
      load_A  <= 1'b0;
      load_B  <= 1'b0;
      mask_A  <= 1'b0;
      mask_B  <= 1'b0;
      csm     <= 1'b0;
      nts     <= 1'b0;
    end else begin
      wr_last <= wr;
      irq_clr <= wev & bus.addr & (sel == 8'h04) & bus.din[7];
      if (wev & ~bus.addr) sel <= bus.din;
      if (wev & bus.addr)
        case (sel)
          8'h02: value_A <= bus.din;
          8'h03: value_B <= bus.din;
          8'h04: if (!bus.din[7]) {mask_A, mask_B, load_B, load_A} <= {bus.din[6], bus.din[5], bus.din[1], bus.din[0]};
          8'h08: {csm, nts} <= bus.din[7:6];
          default: ;
        endcase
    end
  // status byte captured on every status-port read clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.dout <= 8'd0;
    else if (~bus.cs_n & ~bus.rd_n & ~bus.addr) bus.dout <= {flag_A | flag_B, flag_A, flag_B, 5'd0};
  // CSM key-on: set on a timer A overflow edge, held until the next sample slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_d     <= 1'b0;
      csm_keyon <= 1'b0;
    end else begin
      ovf_d <= overflow_A;
      if (rise & csm & load_A) csm_keyon <= 1'b1;
      else if (cenop & zero) csm_keyon <= 1'b0;
    end
endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// tb_jtopl_timer_ctrl: scoreboard bench with a register-map reference model and randomized bus traffic
module tb_jtopl_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cenop = 1'b0, zero = 1'b0;
  logic flag_A = 1'b0, flag_B = 1'b0, overflow_A = 1'b0;
  logic [7:0] value_A, value_B;
  logic load_A, load_B, clr_flag_A, clr_flag_B, flagen_A, flagen_B, csm, nts, csm_keyon;
  int tests = 0, fails = 0, cyc_n = 0;
  jtopl_timer_ctrl_if bus ();
  jtopl_timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cenop(cenop), .zero(zero), .bus(bus),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .flagen_A(flagen_A), .flagen_B(flagen_B),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .csm(csm), .nts(nts), .csm_keyon(csm_keyon)
  );
  always #5 clk = ~clk;
  // reference model: registers kept as the raw bytes the CPU wrote
  logic [7:0] m_sel, r2, r3, r4, r8, m_dout;
  logic m_wr_prev, m_irq, m_ovf_prev, m_keyon;
  logic [32:0] q [$];
  logic [32:0] exp_v, act_v;
  function automatic logic [32:0] model_vec();
    return {r2, r3, m_dout, r4[0], r4[1], m_irq | r4[6], m_irq | r4[5], ~r4[6], ~r4[5], r8[7], r8[6], m_keyon};
  endfunction
  function automatic logic [32:0] dut_vec();
    return {value_A, value_B, bus.dout, load_A, load_B, clr_flag_A, clr_flag_B, flagen_A, flagen_B, csm, nts, csm_keyon};
  endfunction
  task automatic model_step();
    logic ev, rise;
    if (!rst_n) begin
      {m_sel, r2, r3, r4, r8, m_dout} = '0;
      {m_wr_prev, m_irq, m_ovf_prev, m_keyon} = '0;
      return;
    end
    ev = !bus.cs_n && !bus.wr_n && !m_wr_prev;
    rise = overflow_A && !m_ovf_prev;
    if (rise && r8[7] && r4[0]) m_keyon = 1'b1;
    else if (cenop && zero) m_keyon = 1'b0;
    m_irq = ev && bus.addr && m_sel == 8'h04 && bus.din[7];
    if (!bus.cs_n && !bus.rd_n && !bus.addr) m_dout = {flag_A || flag_B, flag_A, flag_B, 5'd0};
    if (ev && !bus.addr) m_sel = bus.din;
    else if (ev) begin
      if (m_sel == 8'h02) r2 = bus.din;
      if (m_sel == 8'h03) r3 = bus.din;
      if (m_sel == 8'h04 && !bus.din[7]) r4 = bus.din;
      if (m_sel == 8'h08) r8 = bus.din;
    end
    m_wr_prev = !bus.cs_n && !bus.wr_n;
    m_ovf_prev = overflow_A;
  endtask
  // drive one clock of bus activity and queue the state expected after its edge
  task automatic cyc(input logic rn, input logic cn, input logic wn, input logic rdn, input logic a, input logic [7:0] d);
    #1;
    rst_n = rn; bus.cs_n = cn; bus.wr_n = wn; bus.rd_n = rdn; bus.addr = a; bus.din = d;
    model_step();
    if (!rn) begin
      #1;
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
      end
    end
    q.push_back(model_vec());
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask
  task automatic wr_op(input logic a, input logic [7:0] d, input int len);
    repeat (len) cyc(1'b1, 1'b0, 1'b0, 1'b1, a, d);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, a, d);
  endtask
  task automatic wreg(input logic [7:0] r, input logic [7:0] d);
    wr_op(1'b0, r, 1);
    wr_op(1'b1, d, 1);
  endtask
  // monitor: every falling edge retires one expected snapshot
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      act_v = dut_vec();
      cyc_n++;
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc_n, act_v, exp_v);
      end
    end
  initial begin
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.addr = 1'b0; bus.din = 8'h00;
    @(negedge clk);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    idle(2);
    wreg(8'h02, 8'hA5);
    wreg(8'h03, 8'h3C);
    wr_op(1'b0, 8'h04, 1);
    wr_op(1'b1, 8'h80, 10);
    wr_op(1'b1, 8'h03, 1);
    wr_op(1'b1, 8'h80, 1);
    wr_op(1'b1, 8'h41, 2);
    flag_A = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
    flag_A = 1'b0; flag_B = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08);
    wr_op(1'b1, 8'h80, 1);
    flag_B = 1'b0;
    overflow_A = 1'b1;
    idle(3);
    cenop = 1'b1; zero = 1'b1;
    idle(1);
    cenop = 1'b0; zero = 1'b0; overflow_A = 1'b0;
    idle(2);
    wreg(8'h08, 8'h00);
    overflow_A = 1'b1;
    idle(2);
    overflow_A = 1'b0;
    wreg(8'h08, 8'h80);
    overflow_A = 1'b1;
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    overflow_A = 1'b0;
    idle(3);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      logic a;
      a = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if (!a) d = (($urandom % 8) == 0) ? d : (($urandom % 2) ? 8'h04 : (($urandom % 2) ? 8'h08 : 8'($urandom_range(2, 3))));
      cenop = 1'($urandom_range(0, 1));
      zero = (($urandom % 3) == 0);
      flag_A = 1'($urandom_range(0, 1));
      flag_B = 1'($urandom_range(0, 1));
      if (($urandom % 6) == 0) overflow_A = ~overflow_A;
      cyc(($urandom % 150) != 0, ($urandom % 5) == 0, ($urandom % 3) != 0, ($urandom % 3) != 0, a, d);
    end
    idle(2);
    #2;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain left=%0d need=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
